// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART RX frame controller and its line/sampler side.
// The master drives the line, configuration and voted bit; the slave is the controller.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_in;
  logic [4:0]            prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  sampled_bit;
  logic [4:0]            edge_cnt;
  logic                  dat_samp_en;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  strt_glitch;

  modport master (
    output RX_in, prescale, par_en, par_typ, sampled_bit,
    input  edge_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err, strt_glitch
  );

  modport slave (
    input  RX_in, prescale, par_en, par_typ, sampled_bit,
    output edge_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err, strt_glitch
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start detect, oversample edge counting, LSB-first deserialise,
// optional parity and stop checking, with registered one-cycle result strobes.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [4:0]            edge_cnt_r;
  logic [IDX_W-1:0]      bit_idx_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic                  par_flag_r;
  logic                  dat_samp_en_r;
  logic                  data_valid_r;
  logic                  par_err_r;
  logic                  stp_err_r;
  logic                  strt_glitch_r;
  logic                  bb_s;
  logic                  last_bit_s;
  logic                  good_stop_s;

  function automatic logic parity_f(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  assign bb_s        = (state_r != IDLE) && (edge_cnt_r == bus.prescale);
  assign last_bit_s  = (bit_idx_r == IDX_W'(DATA_WIDTH - 1));
  assign good_stop_s = bus.sampled_bit && !par_flag_r;

  // Next-state logic; every state advances only on a bit boundary except IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!bus.RX_in) state_s = START;
        else            state_s = IDLE;
      end
      START: begin
        if (bb_s) state_s = bus.sampled_bit ? IDLE : DATA;
        else      state_s = START;
      end
      DATA: begin
        if (bb_s && last_bit_s) state_s = bus.par_en ? PARITY : STOP;
        else                    state_s = DATA;
      end
      PARITY: begin
        if (bb_s) state_s = STOP;
        else      state_s = PARITY;
      end
      STOP: begin
        if (bb_s) state_s = IDLE;
        else      state_s = STOP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register; the sampler enable is registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      dat_samp_en_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      dat_samp_en_r <= (state_s != IDLE);
    end
  end

  // Oversample edge counter, wrapping at prescale so a bit spans prescale+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_r <= 5'd0;
    end else if (state_r == IDLE) begin
      edge_cnt_r <= 5'd0;
    end else if (edge_cnt_r == bus.prescale) begin
      edge_cnt_r <= 5'd0;
    end else begin
      edge_cnt_r <= edge_cnt_r + 5'd1;
    end
  end

  // Deserialiser and parity mismatch flag; both are cleared while waiting for a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx_r  <= {IDX_W{1'b0}};
      shift_r    <= {DATA_WIDTH{1'b0}};
      par_flag_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bit_idx_r  <= {IDX_W{1'b0}};
          par_flag_r <= 1'b0;
        end
        DATA: begin
          if (bb_s) begin
            shift_r   <= {bus.sampled_bit, shift_r[DATA_WIDTH-1:1]};
            bit_idx_r <= bit_idx_r + IDX_W'(1);
          end
        end
        PARITY: begin
          if (bb_s) par_flag_r <= (bus.sampled_bit != parity_f(shift_r, bus.par_typ));
        end
        default: begin
        end
      endcase
    end
  end

  // Result strobes are high only for the cycle after the deciding bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_data_r      <= {DATA_WIDTH{1'b0}};
      data_valid_r  <= 1'b0;
      par_err_r     <= 1'b0;
      stp_err_r     <= 1'b0;
      strt_glitch_r <= 1'b0;
    end else begin
      data_valid_r  <= 1'b0;
      par_err_r     <= 1'b0;
      stp_err_r     <= 1'b0;
      strt_glitch_r <= 1'b0;
      if (bb_s && (state_r == STOP)) begin
        stp_err_r    <= !bus.sampled_bit;
        par_err_r    <= par_flag_r;
        data_valid_r <= good_stop_s;
        if (good_stop_s) p_data_r <= shift_r;
      end
      if (bb_s && (state_r == START) && bus.sampled_bit) strt_glitch_r <= 1'b1;
    end
  end

  assign bus.edge_cnt    = edge_cnt_r;
  assign bus.dat_samp_en = dat_samp_en_r;
  assign bus.P_DATA      = p_data_r;
  assign bus.data_valid  = data_valid_r;
  assign bus.par_err     = par_err_r;
  assign bus.stp_err     = stp_err_r;
  assign bus.strt_glitch = strt_glitch_r;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are driven bit by bit, the expected strobe
// (with its exact cycle) is queued, and a negedge monitor pops and compares each strobe.
module tb_uart_rx_ctrl;
  localparam int DW = 8;

  typedef struct {
    int         cyc;
    logic       v;
    logic       pe;
    logic       se;
    logic       gl;
    logic [7:0] pd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_pdata = 8'h00;
  exp_t       sb_q[$];
  exp_t       mon_e;

  uart_rx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Sets line and voted bit for the next rising edge.
  task automatic drive(input logic rx, input logic sb);
    @(negedge clk);
    bus.RX_in       = rx;
    bus.sampled_bit = sb;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'($urandom_range(0, 1)));
  endtask

  // Expected strobe appears right after the edge following the current negedge.
  task automatic push(input logic v, input logic pe, input logic se, input logic gl);
    exp_t e;
    e.cyc = cyc + 1;
    e.v   = v;
    e.pe  = pe;
    e.se  = se;
    e.gl  = gl;
    e.pd  = model_pdata;
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [4:0] p, input logic pe,
                            input logic pt, input logic pbit, input logic stop);
    logic bits[$];
    int   exp_pbit;
    logic perr;
    logic serr;
    @(negedge clk);
    bus.prescale    = p;
    bus.par_en      = pe;
    bus.par_typ     = pt;
    bus.RX_in       = 1'b0;
    bus.sampled_bit = 1'($urandom_range(0, 1));
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pbit);
    bits.push_back(stop);
    for (int k = 0; k < bits.size(); k++) begin
      for (int j = 0; j <= int'(p); j++) begin
        drive(bits[k], bits[k]);
        if (k == 1 && j == 0) chk("samp_en_busy", 32'(bus.dat_samp_en), 32'd1);
      end
    end
    exp_pbit = ($countones(d) + int'(pt)) % 2;
    perr = pe && (int'(pbit) != exp_pbit);
    serr = !stop;
    if (!perr && !serr) model_pdata = d;
    push(!perr && !serr, perr, serr, 1'b0);
  endtask

  task automatic send_glitch(input logic [4:0] p);
    @(negedge clk);
    bus.prescale    = p;
    bus.RX_in       = 1'b0;
    bus.sampled_bit = 1'b1;
    drive(1'b0, 1'b1);
    for (int j = 1; j <= int'(p); j++) drive(1'b1, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0);
    chk("glitch_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    chk("glitch_samp_en", 32'(bus.dat_samp_en), 32'd0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    if (!rst && (bus.data_valid || bus.par_err || bus.stp_err || bus.strt_glitch)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe v/pe/se/gl=%b%b%b%b at cycle %0d",
                 bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.cyc != cyc || bus.data_valid !== mon_e.v || bus.par_err !== mon_e.pe ||
            bus.stp_err !== mon_e.se || bus.strt_glitch !== mon_e.gl || bus.P_DATA !== mon_e.pd) begin
          errors++;
          $display("FAIL strobe actual cyc=%0d v/pe/se/gl=%b%b%b%b data=%h expected cyc=%0d v/pe/se/gl=%b%b%b%b data=%h",
                   cyc, bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch, bus.P_DATA,
                   mon_e.cyc, mon_e.v, mon_e.pe, mon_e.se, mon_e.gl, mon_e.pd);
        end
      end
    end
  end

  initial begin
    logic [4:0] p;
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       pbit;
    logic       stop;
    rst             = 1'b1;
    bus.RX_in       = 1'b1;
    bus.sampled_bit = 1'b1;
    bus.prescale    = 5'd7;
    bus.par_en      = 1'b0;
    bus.par_typ     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pdata", 32'(bus.P_DATA), 32'd0);
    chk("reset_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    chk("reset_samp_en", 32'(bus.dat_samp_en), 32'd0);
    chk("reset_strobes", 32'({bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch}), 32'd0);
    rst = 1'b0;
    idle(3);

    send_frame(8'h3C, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    send_frame(8'hA5, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    send_frame(8'hA5, 5'd15, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(2);
    send_frame(8'h01, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    send_glitch(5'd7);
    idle(2);
    send_frame(8'h55, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hAA, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Abort a frame in its data bits with an asynchronous reset.
    @(negedge clk);
    bus.prescale    = 5'd7;
    bus.par_en      = 1'b0;
    bus.RX_in       = 1'b0;
    bus.sampled_bit = 1'b0;
    for (int j = 0; j < 8 * 4 + 3; j++) drive(1'b1, (j < 8) ? 1'b0 : 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pdata", 32'(bus.P_DATA), 32'd0);
    chk("midrst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    chk("midrst_samp_en", 32'(bus.dat_samp_en), 32'd0);
    chk("midrst_strobes", 32'({bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch}), 32'd0);
    model_pdata = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
    send_frame(8'h81, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       p = 5'd7;
        1:       p = 5'd15;
        default: p = 5'd31;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        send_glitch(p);
      end else begin
        d    = 8'($urandom_range(0, 255));
        pe   = 1'($urandom_range(0, 1));
        pt   = 1'($urandom_range(0, 1));
        pbit = 1'(($countones(d) + int'(pt)) % 2) ^ 1'($urandom_range(0, 3) == 0);
        stop = 1'($urandom_range(0, 3) != 0);
        send_frame(d, p, pe, pt, pbit, stop);
      end
      idle($urandom_range(0, 3));
    end

    idle(4);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
